// File: rtl/spi_cmd_sequencer_if.sv
// Purpose : word-stream input and register-bank output bundle of spi_cmd_sequencer.
// Ports   : word_valid/word_data (SPI receiver -> sequencer); reg_idx/reg_data/reg_wr
//           (sequencer -> command register bank); busy, frame_ok/frame_err, err_code,
//           ok_cnt/err_cnt status.
// Modports: master = word source / bank observer, slave = the sequencer itself.
interface spi_cmd_sequencer_if;
  logic        word_valid;
  logic [15:0] word_data;
  logic [7:0]  reg_idx;
  logic [15:0] reg_data;
  logic        reg_wr;
  logic        busy;
  logic        frame_ok;
  logic        frame_err;
  logic [1:0]  err_code;
  logic [15:0] ok_cnt;
  logic [15:0] err_cnt;

  modport master (
    output word_valid, word_data,
    input  reg_idx, reg_data, reg_wr, busy, frame_ok, frame_err, err_code, ok_cnt, err_cnt
  );

  modport slave (
    input  word_valid, word_data,
    output reg_idx, reg_data, reg_wr, busy, frame_ok, frame_err, err_code, ok_cnt, err_cnt
  );
endinterface

// File: rtl/spi_cmd_sequencer.sv
// Purpose : validates one SPI command frame (header, length, payload, 16-bit checksum),
//           buffers the payload and only after a checksum match replays it into the
//           register bank as (index, data, write-edge) triplets.
// Latency : checksum word at cycle t -> first reg_wr at t+2, one write every 3 cycles,
//           frame_ok at t+3K+1 for K payload words; frame_err the cycle after the fault.
// Backpressure: none on the word stream; words arriving while committing are dropped.
// Ports   : clk, rst_n (async, active low); bus = spi_cmd_sequencer_if.slave.
module spi_cmd_sequencer #(
  parameter int          MAX_WORDS = 12,
  parameter logic [15:0] HEADER    = 16'hA55A,
  parameter int          TIMEOUT   = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_cmd_sequencer_if.slave   bus
);

  // CW holds a payload count 0..MAX_WORDS; AW addresses the buffer.
  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam int AW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [TW-1:0] TMR_ONE = TW'(1);
  localparam logic [TW-1:0] TMR_MAX = TW'(TIMEOUT);

  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_SUM = 2'd2;
  localparam logic [1:0] ERR_TMO = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CSUM,
    S_C_SETUP,
    S_C_STROBE,
    S_C_HOLD
  } state_t;

  state_t state, state_nxt;

  logic [15:0]   buf_mem [MAX_WORDS];
  logic [CW-1:0] count;
  logic [CW-1:0] wptr;
  logic [CW-1:0] rptr;
  logic [CW-1:0] rptr_nxt;
  logic [15:0]   sum;
  logic [TW-1:0] timer;

  logic [7:0]    reg_idx_q;
  logic [15:0]   reg_data_q;
  logic          frame_ok_q;
  logic          frame_err_q;
  logic [1:0]    err_code_q;
  logic [15:0]   ok_cnt_q;
  logic [15:0]   err_cnt_q;

  // Control strobes produced by the next-state logic for the datapath.
  logic          start_frame;
  logic          len_ok;
  logic          pay_wr;
  logic          load_reg;
  logic          ok_set;
  logic          err_set;
  logic [1:0]    err_cause;

  logic          len_in_range;
  logic          timed_out;
  logic          rx_state;
  logic          last_pay;
  logic          last_commit;

  assign len_in_range = (bus.word_data != 16'd0) && (bus.word_data <= 16'(MAX_WORDS));
  assign timed_out    = (timer == TMR_MAX);
  assign rx_state     = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CSUM);
  assign last_pay     = (wptr == count - CNT_ONE);
  assign last_commit  = (rptr == count - CNT_ONE);

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------- next state
  // An arriving word always wins over a timeout expiring in the same cycle, so a
  // gap of exactly TIMEOUT idle clocks between words is still legal.
  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    len_ok      = 1'b0;
    pay_wr      = 1'b0;
    load_reg    = 1'b0;
    ok_set      = 1'b0;
    err_set     = 1'b0;
    err_cause   = 2'd0;
    rptr_nxt    = rptr;

    case (state)
      S_IDLE: begin
        if (bus.word_valid && (bus.word_data == HEADER)) begin
          start_frame = 1'b1;
          state_nxt   = S_LEN;
        end
      end

      S_LEN: begin
        if (bus.word_valid) begin
          if (len_in_range) begin
            len_ok    = 1'b1;
            state_nxt = S_PAYLOAD;
          end else begin
            err_set   = 1'b1;
            err_cause = ERR_LEN;
            state_nxt = S_IDLE;
          end
        end else if (timed_out) begin
          err_set   = 1'b1;
          err_cause = ERR_TMO;
          state_nxt = S_IDLE;
        end
      end

      S_PAYLOAD: begin
        if (bus.word_valid) begin
          pay_wr = 1'b1;
          if (last_pay) begin
            state_nxt = S_CSUM;
          end
        end else if (timed_out) begin
          err_set   = 1'b1;
          err_cause = ERR_TMO;
          state_nxt = S_IDLE;
        end
      end

      S_CSUM: begin
        if (bus.word_valid) begin
          if (bus.word_data == sum) begin
            rptr_nxt  = '0;
            load_reg  = 1'b1;
            state_nxt = S_C_SETUP;
          end else begin
            err_set   = 1'b1;
            err_cause = ERR_SUM;
            state_nxt = S_IDLE;
          end
        end else if (timed_out) begin
          err_set   = 1'b1;
          err_cause = ERR_TMO;
          state_nxt = S_IDLE;
        end
      end

      S_C_SETUP: begin
        state_nxt = S_C_STROBE;
      end

      S_C_STROBE: begin
        state_nxt = S_C_HOLD;
      end

      S_C_HOLD: begin
        if (last_commit) begin
          ok_set    = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          rptr_nxt  = rptr + CNT_ONE;
          load_reg  = 1'b1;
          state_nxt = S_C_SETUP;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------- receive datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      wptr  <= '0;
      sum   <= '0;
      timer <= '0;
    end else begin
      if (start_frame) begin
        sum <= '0;
      end else if (pay_wr) begin
        sum <= sum + bus.word_data;
      end

      if (len_ok) begin
        count <= bus.word_data[CW-1:0];
        wptr  <= '0;
      end else if (pay_wr) begin
        wptr <= wptr + CNT_ONE;
      end

      // Idle-gap timer only runs while a frame is being received.
      if (rx_state && !bus.word_valid && (state_nxt == state)) begin
        timer <= timer + TMR_ONE;
      end else begin
        timer <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_WORDS; i++) begin
        buf_mem[i] <= '0;
      end
    end else if (pay_wr) begin
      buf_mem[wptr[AW-1:0]] <= bus.word_data;
    end
  end

  // ---------------------------------------------------------------- commit datapath
  // reg_idx/reg_data are loaded on the edge into C_SETUP, so they are already valid
  // during C_SETUP and cannot move while reg_wr is high or during C_HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr       <= '0;
      reg_idx_q  <= '0;
      reg_data_q <= '0;
    end else begin
      rptr <= rptr_nxt;
      if (load_reg) begin
        reg_idx_q  <= 8'(rptr_nxt) + 8'd1;
        reg_data_q <= buf_mem[rptr_nxt[AW-1:0]];
      end
    end
  end

  // ---------------------------------------------------------------- status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
      ok_cnt_q    <= '0;
      err_cnt_q   <= '0;
    end else begin
      frame_ok_q  <= ok_set;
      frame_err_q <= err_set;
      if (ok_set) begin
        ok_cnt_q <= ok_cnt_q + 16'd1;
      end
      if (err_set) begin
        err_code_q <= err_cause;
        err_cnt_q  <= err_cnt_q + 16'd1;
      end
    end
  end

  // reg_wr is decoded straight from the state so reset drops it immediately.
  assign bus.reg_wr    = (state == S_C_STROBE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.reg_idx   = reg_idx_q;
  assign bus.reg_data  = reg_data_q;
  assign bus.frame_ok  = frame_ok_q;
  assign bus.frame_err = frame_err_q;
  assign bus.err_code  = err_code_q;
  assign bus.ok_cnt    = ok_cnt_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Testbench for spi_cmd_sequencer: directed frames from the test plan, randomized
// frames checked against a frame-level reference model, timeout and mid-commit reset.
module tb_spi_cmd_sequencer;
  localparam int          MAXW = 12;
  localparam logic [15:0] HDR  = 16'hA55A;
  localparam int          TMO  = 1000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_cmd_sequencer_if bus();

  spi_cmd_sequencer #(
    .MAX_WORDS (MAXW),
    .HEADER    (HDR),
    .TIMEOUT   (TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t_last = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- monitor
  typedef struct {
    int          stamp;
    logic [7:0]  idx;
    logic [15:0] dat;
    logic [7:0]  idx_h;
    logic [15:0] dat_h;
  } wr_t;

  wr_t  obs_q[$];
  wr_t  w_new, w_last;
  int   ok_pulses = 0, err_pulses = 0, last_ok_cyc = -1, last_err_cyc = -1;
  logic prev_wr = 1'b0;
  logic hold_pending = 1'b0;

  always @(negedge clk) begin
    if (hold_pending && obs_q.size() > 0) begin
      w_last       = obs_q.pop_back();
      w_last.idx_h = bus.reg_idx;
      w_last.dat_h = bus.reg_data;
      obs_q.push_back(w_last);
    end
    hold_pending = 1'b0;
    if (bus.reg_wr && !prev_wr) begin
      w_new.stamp = cyc;
      w_new.idx   = bus.reg_idx;
      w_new.dat   = bus.reg_data;
      w_new.idx_h = 'x;
      w_new.dat_h = 'x;
      obs_q.push_back(w_new);
      hold_pending = 1'b1;
    end
    prev_wr = bus.reg_wr;
    if (bus.frame_ok)  begin ok_pulses++;  last_ok_cyc  = cyc; end
    if (bus.frame_err) begin err_pulses++; last_err_cyc = cyc; end
  end

  // ---------------------------------------------------------------- checking
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_idx"},   32'(bus.reg_idx),   0);
    check({tag, "_dat"},   32'(bus.reg_data),  0);
    check({tag, "_wr"},    32'(bus.reg_wr),    0);
    check({tag, "_busy"},  32'(bus.busy),      0);
    check({tag, "_ok"},    32'(bus.frame_ok),  0);
    check({tag, "_err"},   32'(bus.frame_err), 0);
    check({tag, "_code"},  32'(bus.err_code),  0);
    check({tag, "_okc"},   32'(bus.ok_cnt),    0);
    check({tag, "_errc"},  32'(bus.err_cnt),   0);
  endtask

  // ---------------------------------------------------------------- reference model
  // Frame-level view: a frame is accepted iff its length is 1..MAXW and the last word
  // equals the 16-bit wrapping sum of the payload; accepted payload is written to
  // indices 1..K in order.
  logic [15:0] exp_d[$];
  int          exp_ok = 0, exp_err = 0;
  logic [1:0]  exp_code = 2'd0;

  function automatic int predict(input logic [15:0] f[$]);
    logic [15:0] s;
    int          n;
    exp_d.delete();
    n = int'(f[1]);
    if (n < 1 || n > MAXW) return 1;
    s = 16'd0;
    for (int i = 0; i < n; i++) begin
      s = s + f[2 + i];
      exp_d.push_back(f[2 + i]);
    end
    if (f[2 + n] !== s) begin
      exp_d.delete();
      return 2;
    end
    return 0;
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic put(input logic [15:0] w);
    @(negedge clk);
    bus.word_valid = 1'b1;
    bus.word_data  = w;
    t_last         = cyc;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.word_valid = 1'b0;
      bus.word_data  = 16'($urandom);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_okc"},  32'(bus.ok_cnt),   32'(exp_ok));
    check({tag, "_errc"}, 32'(bus.err_cnt),  32'(exp_err));
    check({tag, "_code"}, 32'(bus.err_code), 32'(exp_code));
    check({tag, "_busy"}, 32'(bus.busy),     0);
  endtask

  // Drive one frame, wait out the longest possible commit, compare to the model.
  task automatic run_frame(input string tag, input logic [15:0] f[$], input int gmax,
                           input int long_at);
    int code, k, ok0, err0, t, n;
    code = predict(f);
    k    = exp_d.size();
    ok0  = ok_pulses;
    err0 = err_pulses;
    obs_q.delete();
    for (int i = 0; i < f.size(); i++) begin
      put(f[i]);
      if (i < f.size() - 1) gap((i == long_at) ? TMO - 1 : int'($urandom_range(0, gmax)));
    end
    t = t_last;
    gap(1);
    repeat (3 * MAXW + 6) @(negedge clk);
    #1;
    check({tag, "_nwr"}, 32'(obs_q.size()), 32'(k));
    n = (obs_q.size() < k) ? obs_q.size() : k;
    if (code == 0) begin
      exp_ok++;
      for (int i = 0; i < n; i++) begin
        check({tag, "_idx"},   32'(obs_q[i].idx),   32'(i + 1));
        check({tag, "_dat"},   32'(obs_q[i].dat),   32'(exp_d[i]));
        check({tag, "_at"},    32'(obs_q[i].stamp), 32'(t + 2 + 3 * i));
        check({tag, "_idxh"},  32'(obs_q[i].idx_h), 32'(i + 1));
        check({tag, "_dath"},  32'(obs_q[i].dat_h), 32'(exp_d[i]));
      end
      check({tag, "_okp"},  32'(ok_pulses - ok0),   1);
      check({tag, "_okat"}, 32'(last_ok_cyc),       32'(t + 3 * k + 1));
      check({tag, "_errp"}, 32'(err_pulses - err0), 0);
    end else begin
      exp_err++;
      exp_code = 2'(code);
      check({tag, "_errp"},  32'(err_pulses - err0), 1);
      check({tag, "_errat"}, 32'(last_err_cyc),      32'(t + 1));
      check({tag, "_okp"},   32'(ok_pulses - ok0),   0);
    end
    check_status(tag);
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  logic [15:0] f[$];
  logic [15:0] s, w, flip;
  int          len, kind, ok0, err0, t;

  initial begin
    bus.word_valid = 1'b0;
    bus.word_data  = 16'h0;

    // Reset state, during and just after reset.
    repeat (3) @(negedge clk);
    check_reset_vals("rst_in");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("rst_out");

    // Basic two-word frame, then the same frame with a bad checksum, then recovery.
    f = '{16'hA55A, 16'h0002, 16'h1234, 16'h0010, 16'h1244};
    run_frame("good2", f, 0, -1);
    f = '{16'hA55A, 16'h0002, 16'h1234, 16'h0010, 16'h1245};
    run_frame("badsum", f, 0, -1);
    f = '{16'hA55A, 16'h0002, 16'h1234, 16'h0010, 16'h1244};
    run_frame("again", f, 0, -1);

    // Length out of range at both ends.
    f = '{16'hA55A, 16'h0000};
    run_frame("len0", f, 0, -1);
    f = '{16'hA55A, 16'h000D};
    run_frame("len13", f, 0, -1);

    // Maximum-length frame whose sum wraps: 12 x F000 -> 4000.
    f = '{16'hA55A, 16'd12};
    for (int i = 0; i < 12; i++) f.push_back(16'hF000);
    f.push_back(16'h4000);
    run_frame("max12", f, 0, -1);

    // Header value inside the payload is plain data.
    f = '{16'hA55A, 16'h0003, 16'hA55A, 16'h0001, 16'hA55A, 16'h4AB5};
    run_frame("hdrdata", f, 0, -1);

    // A gap just under the timeout between payload words is still legal.
    f = '{16'hA55A, 16'h0003, 16'h0001, 16'h0002, 16'h0003, 16'h0006};
    run_frame("longgap", f, 0, 3);

    // Stall after 3 of 5 payload words -> timeout error.
    ok0 = ok_pulses; err0 = err_pulses; obs_q.delete();
    put(HDR); put(16'h0005); put(16'h0011); put(16'h0022); put(16'h0033);
    t = t_last;
    gap(TMO + 8);
    #1;
    exp_err++; exp_code = 2'd3;
    check("tmo_errp", 32'(err_pulses - err0), 1);
    check("tmo_at", 32'((last_err_cyc >= t + TMO + 1) && (last_err_cyc <= t + TMO + 2)), 1);
    check("tmo_nwr", 32'(obs_q.size()), 0);
    check_status("tmo");
    // Stray words after the error are dropped silently.
    put(16'h0011); put(16'h0003); gap(6); #1;
    check("stray_errp", 32'(err_pulses - err0), 1);
    check("stray_okp",  32'(ok_pulses - ok0),  0);
    check_status("stray");
    f = '{16'hA55A, 16'h0001, 16'hBEEF, 16'hBEEF};
    run_frame("after_tmo", f, 0, -1);

    // Randomized frames with small gaps: mostly good, some bad length / checksum.
    for (int n = 0; n < 30; n++) begin
      len  = int'($urandom_range(1, MAXW));
      kind = int'($urandom_range(0, 9));
      f.delete();
      f.push_back(HDR);
      if (kind == 0) begin
        f.push_back(($urandom_range(0, 1) == 0) ? 16'h0000 : 16'($urandom_range(MAXW + 1, 16'hFFFF)));
      end else begin
        f.push_back(16'(len));
        s = 16'h0;
        for (int i = 0; i < len; i++) begin
          w = 16'($urandom);
          s = s + w;
          f.push_back(w);
        end
        flip = 16'h1 << $urandom_range(0, 15);
        f.push_back((kind == 1) ? (s ^ flip) : s);
      end
      run_frame("rand", f, 2, -1);
    end

    // Reset asserted during the second write strobe of a 4-word commit.
    f = '{16'hA55A, 16'h0004, 16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0A0A};
    obs_q.delete();
    ok0 = ok_pulses;
    for (int i = 0; i < f.size(); i++) put(f[i]);
    t = t_last;
    gap(1);
    repeat (4) @(negedge clk);
    #1;
    check("mid_wr",  32'(bus.reg_wr),   1);
    check("mid_idx", 32'(bus.reg_idx),  2);
    check("mid_nwr", 32'(obs_q.size()), 2);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_ok = 0; exp_err = 0; exp_code = 2'd0;
    put(16'h0004); put(16'h0303); put(16'h1234);
    gap(3 * MAXW + 6);
    #1;
    check("post_nwr", 32'(obs_q.size()), 2);
    check("post_okp", 32'(ok_pulses - ok0), 0);
    check_status("post");
    f = '{16'hA55A, 16'h0002, 16'h1234, 16'h0010, 16'h1244};
    run_frame("recover", f, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
